// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM state enum and misalignment rule shared by the data-memory master
package dmem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SIZE_HALF && lo[0]) || (size[1] && lo != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: byte-lane select, store replication and load extraction/extension (we/size/lo/uns/wdata/bus_rdata in; sel/store_data/load_data out)
module dmem_align import dmem_pkg::*; (
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);
  logic [31:0] shifted;
  always_comb begin
    shifted = bus_rdata >> {lo, 3'b000};
    sel = (!we || size[1]) ? 4'hf : (size == SIZE_HALF) ? 4'b0011 << lo : 4'b0001 << lo;
    store_data = size[1] ? wdata : (size == SIZE_HALF) ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    load_data = size[1] ? shifted :
                (size == SIZE_HALF) ? {{16{~uns & shifted[15]}}, shifted[15:0]} :
                {{24{~uns & shifted[7]}}, shifted[7:0]};
  end
endmodule

// File: rtl/dmem_master.sv
// dmem_master: MEM-stage load/store to Wishbone classic initiator (req/we/addr/wdata/size/unsigned in; rdata/busy/misaligned out; wb_* bus)
module dmem_master import dmem_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  misaligned_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);
  dmem_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0] wdata_q, st_data, ld_data;
  logic [1:0] size_q;
  logic we_q, uns_q, mis;
  logic [3:0] sel;
  dmem_align u_align (
    .we(we_q), .size(size_q), .lo(addr_q[1:0]), .uns(uns_q), .wdata(wdata_q),
    .bus_rdata(wb_dat_i), .sel(sel), .store_data(st_data), .load_data(ld_data)
  );
  always_comb begin
    mis = is_misaligned(size_i, addr_i[1:0]);
    state_n = (state == IDLE) ? (req_i ? (mis ? DONE : BUSY) : IDLE) :
              (state == BUSY) ? (wb_ack_i ? DONE : BUSY) : IDLE;
    busy_o = (state == IDLE && req_i) || state == BUSY;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      misaligned_o <= 1'b0;
      rdata_o <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= SIZE_WORD;
      we_q <= 1'b0;
      uns_q <= 1'b0;
    end else begin
      state <= state_n;
      misaligned_o <= state == IDLE && req_i && mis;
      if (state == IDLE && req_i && !mis) begin
        addr_q <= addr_i;
        wdata_q <= wdata_i;
        size_q <= size_i;
        we_q <= we_i;
        uns_q <= unsigned_i;
      end
      if (state == BUSY && wb_ack_i && !we_q) rdata_o <= ld_data;
    end
  end
  assign wb_cyc_o = state == BUSY;
  assign wb_stb_o = state == BUSY;
  assign wb_we_o = state == BUSY && we_q;
  assign wb_sel_o = (state == BUSY) ? sel : 4'h0;
  assign wb_adr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign wb_dat_o = st_data;
endmodule

// File: tb/tb_dmem_master.sv
// tb_dmem_master: table-driven and randomized checks of dmem_master against a byte-level reference model
module tb_dmem_master;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] dat;
    int          wt;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [31:0] rdata;
    logic        mis;
  } vec_t;
  logic clk = 0, rst_n = 0, req = 0, we = 0, uns = 0, ack = 0;
  logic [31:0] addr = 0, wdata = 0, dat = 0;
  logic [1:0] size = 0;
  logic [31:0] rdata, adr_o, dat_o;
  logic busy, mis_o, cyc, stb, we_o;
  logic [3:0] sel_o;
  logic [31:0] model_rd = 0;
  int n_vec = 0, n_err = 0;
  vec_t tbl[13];
  always #5 clk = ~clk;
  dmem_master dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .size_i(size), .unsigned_i(uns), .rdata_o(rdata), .busy_o(busy), .misaligned_o(mis_o),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we_o), .wb_adr_o(adr_o), .wb_dat_o(dat_o),
    .wb_sel_o(sel_o), .wb_dat_i(dat), .wb_ack_i(ack)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s,
                              input logic u, input logic [31:0] d, input int t, input logic [3:0] sl,
                              input logic [31:0] dout, input logic [31:0] rd, input logic m);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = wd; v.size = s; v.uns = u; v.dat = d; v.wt = t;
    v.sel = sl; v.dat_o = dout; v.rdata = rd; v.mis = m;
    return v;
  endfunction
  function automatic vec_t model(input logic [31:0] prev);
    vec_t v;
    int n, a;
    logic [31:0] mask, val;
    v.we = 1'($urandom_range(0, 1)); v.addr = $urandom; v.size = 2'($urandom_range(0, 3));
    v.uns = 1'($urandom_range(0, 1)); v.wdata = $urandom; v.dat = $urandom; v.wt = $urandom_range(1, 4);
    n = (v.size == 0) ? 1 : (v.size == 1) ? 2 : 4;
    a = int'(v.addr % 4);
    v.mis = (a % n) != 0;
    v.sel = v.we ? 4'(((1 << n) - 1) << a) : 4'hf;
    for (int i = 0; i < 4; i++) v.dat_o[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    mask = (n == 4) ? 32'hffff_ffff : (32'h1 << (8 * n)) - 1;
    val = (v.dat >> (8 * a)) & mask;
    if (!v.uns && n < 4 && val[8*n-1]) val = val | ~mask;
    v.rdata = (v.we || v.mis) ? prev : val;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int nb;
    nb = 0;
    req = 1; we = v.we; addr = v.addr; wdata = v.wdata; size = v.size; uns = v.uns; dat = v.dat;
    @(negedge clk); chk("busy_req", busy, 1); nb += int'(busy);
    @(posedge clk); #1;
    req = 0; we = 1'($urandom); addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = 1'($urandom);
    if (v.mis) begin
      @(negedge clk);
      nb += int'(busy);
      chk("mis_pulse", mis_o, 1);
      chk("mis_cyc", cyc, 0);
      @(posedge clk); #1;
      chk("mis_clear", mis_o, 0);
    end else begin
      for (int k = 1; k <= v.wt; k++) begin
        if (k == v.wt) ack = 1;
        @(negedge clk);
        nb += int'(busy);
        chk("cyc_stb", {cyc, stb}, 2'b11);
        chk("wb_we", we_o, v.we);
        chk("sel", sel_o, v.sel);
        chk("adr", adr_o, v.addr & ~32'h3);
        if (v.we) chk("dat_o", dat_o, v.dat_o);
        @(posedge clk); #1;
        ack = 0;
      end
      @(negedge clk);
      nb += int'(busy);
      chk("cyc_done", cyc, 0);
      @(posedge clk); #1;
    end
    chk("rdata", rdata, v.rdata);
    chk("busy_cycles", nb, v.mis ? 1 : v.wt + 1);
    model_rd = v.rdata;
  endtask
  initial begin
    logic [6:0] cyc_tr, busy_tr;
    tbl[0]  = mk(0, 32'h8000_0004, 0, 2'b10, 0, 32'hDEAD_BEEF, 3, 4'hf, 0, 32'hDEAD_BEEF, 0);
    tbl[1]  = mk(0, 32'h8000_0003, 0, 2'b00, 0, 32'h80FF_FF7F, 1, 4'hf, 0, 32'hFFFF_FF80, 0);
    tbl[2]  = mk(0, 32'h8000_0003, 0, 2'b00, 1, 32'h80FF_FF7F, 2, 4'hf, 0, 32'h0000_0080, 0);
    tbl[3]  = mk(1, 32'h8000_0002, 32'h1234_ABCD, 2'b01, 0, 32'h5555_5555, 1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 0);
    tbl[4]  = mk(0, 32'h8000_0001, 0, 2'b10, 0, 32'h1111_1111, 1, 4'h0, 0, 32'h0000_0080, 1);
    tbl[5]  = mk(1, 32'h1000_0001, 32'h0000_00A5, 2'b00, 0, 0, 2, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0080, 0);
    tbl[6]  = mk(1, 32'h0000_0020, 32'h1122_3344, 2'b10, 0, 0, 1, 4'hf, 32'h1122_3344, 32'h0000_0080, 0);
    tbl[7]  = mk(0, 32'h0000_8002, 0, 2'b01, 0, 32'h8001_7FFF, 1, 4'hf, 0, 32'hFFFF_8001, 0);
    tbl[8]  = mk(0, 32'h0000_0000, 0, 2'b01, 1, 32'h8001_F00F, 4, 4'hf, 0, 32'h0000_F00F, 0);
    tbl[9]  = mk(1, 32'h0000_0003, 32'hFFFF_FFFF, 2'b01, 0, 0, 1, 4'h0, 0, 32'h0000_F00F, 1);
    tbl[10] = mk(0, 32'h0000_0006, 0, 2'b11, 0, 32'h1234_5678, 1, 4'h0, 0, 32'h0000_F00F, 1);
    tbl[11] = mk(0, 32'h0000_0008, 0, 2'b11, 0, 32'hCAFE_BABE, 2, 4'hf, 0, 32'hCAFE_BABE, 0);
    tbl[12] = mk(0, 32'h0000_0001, 0, 2'b00, 0, 32'h0000_7F00, 1, 4'hf, 0, 32'h0000_007F, 0);
    req = 1; addr = tbl[0].addr; size = tbl[0].size; dat = tbl[0].dat;
    #1;
    chk("rst_cyc_stb_we", {cyc, stb, we_o}, 3'b000);
    chk("rst_sel", sel_o, 4'h0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mis", mis_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    foreach (tbl[i]) run(tbl[i]);
    req = 1; we = 0; size = 2'b10; uns = 0; addr = 32'h8000_0010; dat = 32'h7777_7777;
    @(posedge clk); #1;
    req = 0;
    @(negedge clk); chk("rstmid_cyc_before", cyc, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("rstmid_cyc_stb", {cyc, stb}, 2'b00);
    chk("rstmid_sel_we", {sel_o, we_o}, 5'b0);
    chk("rstmid_rdata", rdata, 0);
    chk("rstmid_mis", mis_o, 0);
    ack = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_cyc", cyc, 0);
      chk("stray_ack_busy", busy, 0);
      chk("stray_ack_rdata", rdata, 0);
    end
    @(posedge clk); #1;
    ack = 0;
    model_rd = 0;
    req = 1; we = 0; size = 2'b10; uns = 0; addr = 32'h40; dat = 32'h1111_1111;
    for (int c = 0; c < 7; c++) begin
      ack = (c == 1 || c == 4);
      if (c == 2) begin addr = 32'h44; dat = 32'h2222_2222; end
      if (c == 5) req = 0;
      @(negedge clk);
      cyc_tr[6-c] = cyc;
      busy_tr[6-c] = busy;
      @(posedge clk); #1;
    end
    ack = 0;
    chk("b2b_cyc", cyc_tr, 7'b0100100);
    chk("b2b_busy", busy_tr, 7'b1101100);
    chk("b2b_rdata", rdata, 32'h2222_2222);
    model_rd = 32'h2222_2222;
    for (int i = 0; i < 40; i++) run(model(model_rd));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
